// File: rtl/minmax_accum.sv
// minmax_accum
//   Output accumulator sitting right after the min/max reduction trees.
//   Each output element is seeded from its C-matrix value, then KSTEPS tree
//   partials are folded in with a running max (max-min semiring, mode=0) or
//   a running min (min-max semiring, mode=1). The result is held under a
//   valid/ready handshake until the consumer takes it.
//
// Ports
//   clk         in   1  rising-edge clock
//   rst         in   1  asynchronous active-high reset
//   start       in   1  begin element (honoured in IDLE, or in DONE with out_ready)
//   mode        in   1  0 = max-accumulate, 1 = min-accumulate
//   c_in        in   W  seed value
//   part_valid  in   1  tree partial present on part_in
//   part_in     in   W  reduction-tree output
//   part_ready  out  1  partial accepted when part_valid & part_ready
//   out_valid   out  1  accumulated result available
//   out_ready   in   1  consumer takes result when out_valid & out_ready
//   out_data    out  W  accumulated result (equals acc in every state)
//   busy        out  1  high while accumulating or holding a result

module minmax_accum #(
  parameter int W      = 16,
  parameter int KSTEPS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] c_in,
  input  logic         part_valid,
  input  logic [W-1:0] part_in,
  output logic         part_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int CW = $clog2(KSTEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(KSTEPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          mode_q;
  logic [W-1:0]  folded;

  // Unsigned compare on raw bits; on a tie acc is kept, which is the same
  // value either way.
  always_comb begin
    folded = acc;
    if (mode_q) begin
      if (part_in < acc) folded = part_in;
    end else begin
      if (part_in > acc) folded = part_in;
    end
  end

  // Single state machine; handshake outputs are registered alongside the
  // state so they change exactly with the state transitions. A start seen
  // together with out_ready in DONE reseeds directly, skipping IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      mode_q     <= 1'b0;
      part_ready <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc        <= c_in;
            mode_q     <= mode;
            cnt        <= '0;
            state      <= ACCUM;
            part_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ACCUM: begin
          if (part_valid) begin
            acc <= folded;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state      <= DONE;
              part_ready <= 1'b0;
              out_valid  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              acc        <= c_in;
              mode_q     <= mode;
              cnt        <= '0;
              state      <= ACCUM;
              part_ready <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          part_ready <= 1'b0;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = acc;

endmodule
